rr_arbiter8x3: RTL

Round-robin arbiter that shares one downstream resource between 8 requesters.
It issues a registered one-hot grant plus the 3-bit encoded grant index, using the same 8-to-3 mapping as the team's 8x3 encoder.
The grant is held while the winner keeps its request high. Fairness rotates past the last winner.
It sits between requester blocks and the shared datapath; gnt_idx drives the datapath's select.

---
 rtl/rr_arbiter8x3.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter8x3.sv
// rr_arbiter8x3 - round-robin arbiter sharing one downstream resource among
// eight requesters. Produces a registered one-hot grant, the matching 3-bit
// index (same 8-to-3 mapping as the 8x3 encoder), a valid flag and a busy
// flag. A winner keeps the grant while its request stays high. On release,
// priority rotates to the position just past the released winner.
//
// Optional build macro: ARB_HOLD_LIMIT_EN
//   When defined, a winner that has held the grant for MAX_HOLD cycles is
//   forcibly rotated out if any other requester is waiting.
//   When undefined, no hold counter exists and a winner may hold forever.
module rr_arbiter8x3 #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // MAX_HOLD must fit the 8-bit hold counter and allow at least one
    // hold cycle before a forced hand-off; nothing is built for bad values.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    end

    // Binary index to one-hot grant vector.
    function automatic logic [7:0] dec3x8(input logic [2:0] idx);
        logic [7:0] vec;
        vec      = 8'h00;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Rotating priority search: first set bit of r at or after start
    // (mod 8). Result is {found, index}; index is 0 when nothing is found.
    function automatic logic [3:0] rr_pick(input logic [7:0] r,
                                           input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            pos = start + i[2:0];
            if (!res[3] && r[pos]) begin
                res = {1'b1, pos};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] ptr_r,   ptr_s;
    logic [7:0] gnt_r,   gnt_s;
    logic [2:0] idx_r,   idx_s;
    logic       valid_r, valid_s;
    logic       busy_r,  busy_s;

    logic [2:0] start_s;
    logic [3:0] pick_s;
    logic       rotate_s;

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic       others_s;
    logic       hold_expired_s;
`endif

    // Search start: the rotating pointer when idle, just past the current
    // winner when a grant is being released or rotated.
    always_comb begin
        if (state_r == GRANT) begin
            start_s = idx_r + 3'd1;
        end else begin
            start_s = ptr_r;
        end
    end

    assign pick_s = rr_pick(req, start_s);

`ifdef ARB_HOLD_LIMIT_EN
    assign others_s       = |(req & ~gnt_r);
    assign hold_expired_s = (hold_cnt_r == 8'(MAX_HOLD)) && others_s;
    assign rotate_s       = ~req[idx_r] | hold_expired_s;
`else
    assign rotate_s       = ~req[idx_r];
`endif

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gnt_s   = gnt_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        busy_s  = busy_r;
`ifdef ARB_HOLD_LIMIT_EN
        hold_cnt_s = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_s[3]) begin
                    state_s = GRANT;
                    gnt_s   = dec3x8(pick_s[2:0]);
                    idx_s   = pick_s[2:0];
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_s = 8'd1;
`endif
                end else begin
                    state_s = IDLE;
                    gnt_s   = 8'h00;
                    idx_s   = 3'd0;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_cnt_s = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (rotate_s) begin
                    // The released winner moves to the back of the queue.
                    ptr_s = idx_r + 3'd1;
                    if (pick_s[3]) begin
                        // Hand off on this edge with no dead cycle.
                        state_s = GRANT;
                        gnt_s   = dec3x8(pick_s[2:0]);
                        idx_s   = pick_s[2:0];
                        valid_s = 1'b1;
                        busy_s  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt_s = 8'd1;
`endif
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 8'h00;
                        idx_s   = 3'd0;
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt_s = 8'd0;
`endif
                    end
                end else begin
                    // Winner keeps the grant; other requests are ignored.
                    state_s = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_cnt_r < 8'(MAX_HOLD)) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = 8'(MAX_HOLD);
                    end
`endif
                end
            end
            default: begin
                state_s = IDLE;
                ptr_s   = 3'd0;
                gnt_s   = 8'h00;
                idx_s   = 3'd0;
                valid_s = 1'b0;
                busy_s  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
                hold_cnt_s = 8'd0;
`endif
            end
        endcase
    end

    // State, pointer and registered-output flops with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 3'd0;
            gnt_r   <= 8'h00;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gnt_r   <= gnt_s;
            idx_r   <= idx_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Consecutive-grant-cycle counter for the current winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`endif

    assign gnt       = gnt_r;
    assign gnt_idx   = idx_r;
    assign gnt_valid = valid_r;
    assign busy      = busy_r;

endmodule
